// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: show-ahead receive FIFO between the receive UART and the CPU read port.
// Holds the level count and a sticky overrun flag; reset masks the outputs combinationally.
module uart_rx_fifo #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          uart_valid,
  input  logic [DW-1:0] uart_data,
  output logic          uart_rd,
  input  logic          rd,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [AW:0]   level,
  output logic          overrun,
  input  logic          clr_overrun
);
  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_level;
  logic          r_overrun;
  logic          w_full, w_pop, w_wr, w_discard;
  always_comb begin
    w_full    = r_level == (AW+1)'(2**AW);
    valid     = !reset && r_level != '0;
    level     = reset ? '0 : r_level;
    overrun   = !reset && r_overrun;
    uart_rd   = uart_valid && !reset;
    data      = r_mem[r_rptr];
    w_pop     = rd && valid;
    w_wr      = uart_rd && (!w_full || w_pop);
    w_discard = uart_rd && w_full && !w_pop;
  end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wptr] <= uart_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_wptr    <= w_wr ? r_wptr + 1'b1 : r_wptr;
      r_rptr    <= w_pop ? r_rptr + 1'b1 : r_rptr;
      r_level   <= (w_wr && !w_pop) ? r_level + 1'b1 : (!w_wr && w_pop) ? r_level - 1'b1 : r_level;
      r_overrun <= w_discard ? 1'b1 : clr_overrun ? 1'b0 : r_overrun;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: queue-scoreboard bench for uart_rx_fifo.
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       reset = 1'b1, uart_valid = 1'b0, rd = 1'b0, clr_overrun = 1'b0;
  logic [7:0] uart_data = 8'h00;
  logic       uart_rd, valid, overrun;
  logic [7:0] data;
  logic [4:0] level;
  logic [7:0] q[$];
  logic       m_ovr = 1'b0;
  int         checks = 0, failures = 0;

  uart_rx_fifo #(.AW(4), .DW(8)) dut (
    .clk(clk), .reset(reset), .uart_valid(uart_valid), .uart_data(uart_data),
    .uart_rd(uart_rd), .rd(rd), .valid(valid), .data(data), .level(level),
    .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, check outputs against the queue model before the edge, then update the model.
  task automatic step(input logic rs, input logic v, input logic [7:0] d, input logic r, input logic c);
    logic full, pop;
    logic [7:0] exp_d;
    reset = rs; uart_valid = v; uart_data = d; rd = r; clr_overrun = c;
    @(negedge clk);
    if (rs) begin
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_uart_rd", 32'(uart_rd), 32'd0);
      q.delete();
      m_ovr = 1'b0;
    end else begin
      chk("valid", 32'(valid), 32'(q.size() > 0));
      chk("level", 32'(level), 32'(q.size()));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("uart_rd", 32'(uart_rd), 32'(v));
      full = q.size() == 16;
      pop = r && q.size() > 0;
      if (pop) begin
        exp_d = q.pop_front();
        chk("pop_data", 32'(data), 32'(exp_d));
      end
      if (v && (!full || pop)) q.push_back(d);
      if (v && full && !pop) m_ovr = 1'b1;
      else if (c) m_ovr = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d); step(0, 1, d, 0, 0); endtask
  task automatic pop1(); step(0, 0, 8'h00, 1, 0); endtask
  task automatic idle(); step(0, 0, 8'h00, 0, 0); endtask

  initial begin
    step(1, 0, 8'h00, 0, 0);
    step(1, 0, 8'h00, 0, 0);
    // single byte
    push(8'h41); idle(); pop1(); idle();
    // ordering and pointer wrap
    for (int i = 0; i < 16; i++) push(8'(i));
    idle();
    for (int i = 0; i < 16; i++) pop1();
    for (int i = 16; i < 24; i++) push(8'(i));
    for (int i = 0; i < 8; i++) pop1();
    idle();
    // full and discard, then clear
    for (int i = 0; i < 17; i++) push(8'(8'hA0 + i));
    idle();
    step(0, 0, 8'h00, 0, 1);
    for (int i = 0; i < 16; i++) pop1();
    idle();
    // simultaneous write and pop while full
    for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
    step(0, 1, 8'hC0, 1, 0);
    idle();
    for (int i = 0; i < 16; i++) pop1();
    // simultaneous write and pop while empty
    step(0, 1, 8'hD0, 1, 0);
    idle();
    pop1(); idle();
    // discard racing clear, then reads while empty
    for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
    step(0, 1, 8'hE0, 0, 1);
    idle();
    for (int i = 0; i < 16; i++) pop1();
    pop1(); pop1();
    push(8'hF1); idle(); pop1(); idle();
    // reset mid-stream with a held UART byte
    for (int i = 0; i < 17; i++) push(8'(8'h30 + i));
    for (int i = 0; i < 11; i++) pop1();
    idle();
    step(1, 1, 8'h5A, 0, 0);
    push(8'h5A);
    idle();
    pop1(); idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer sitting directly downstream of the receive UART (valid/data/rd strobe interface) and upstream of the CPU I/O read port.
- Drains each received character from the UART in the cycle it becomes valid, stores it in a small show-ahead FIFO, and presents it to the CPU with its own valid/read-strobe handshake.
- Counts queued bytes and raises a sticky overrun flag when a character is discarded because the buffer is full.

Parameters:
- AW, 4, address width; FIFO depth = 2**AW entries (default 16).
- DW, 8, data width in bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- uart_valid  in  1  receive UART holds a completed character.
- uart_data  in  DW  character from the receive UART; meaningful only while uart_valid=1.
- uart_rd  out  1  read strobe to the receive UART; combinational, one cycle per character.
- rd  in  1  CPU read strobe; pops the head entry.
- valid  out  1  FIFO non-empty.
- data  out  DW  head entry (show-ahead).
- level  out  AW+1  number of stored entries, 0..2**AW.
- overrun  out  1  sticky: at least one character was discarded.
- clr_overrun  in  1  clears overrun.

Behaviour:
- Reset (reset=1 at a clk edge): write pointer, read pointer and level go to 0, and overrun goes to 0. While reset=1, outputs are valid=0, level=0, overrun=0 and uart_rd=0. data is don't-care when valid=0. RAM contents are not cleared.
- Reset applied mid-operation discards all queued bytes. A uart_valid present during reset is not acknowledged; it is taken on the first cycle after reset deasserts.
- Ingest:
  - uart_rd = uart_valid & !reset, every cycle. The UART drops uart_valid the cycle after uart_rd, so each character is acknowledged exactly once. No internal hold-off state is needed, but uart_rd must never be asserted while uart_valid=0.
  - wr = uart_valid & (!full | pop).
  - full = (level == 2**AW); pop = rd & valid.
- Write: mem[wptr] <= uart_data; wptr increments modulo 2**AW. Pointers are AW bits and wrap naturally.
- Discard: uart_valid & full & !pop. The byte is still acknowledged (uart_rd=1) so the UART returns to idle and keeps receiving. The byte is dropped, overrun <= 1, and level and pointers are unchanged.
- Pop: rd & valid advances rptr modulo 2**AW. rd while empty is ignored: no pointer change, no underflow.
- Level: +1 on wr only, -1 on pop only, unchanged on both or neither. It never exceeds 2**AW and never goes below 0.
- Simultaneous write and pop:
  - When empty: the pop is ignored (valid=0) and the write is stored; valid=1 next cycle.
  - When full: both happen; level stays 2**AW; no overrun.
- Output latency:
  - A byte accepted at edge N is visible on data with valid=1 after edge N (zero-wait show-ahead, combinational read of mem[rptr]).
  - After a pop at edge N, data shows the next entry after edge N.
- overrun:
  - Set on discard; cleared by clr_overrun.
  - If clr_overrun and a discard occur in the same cycle, set wins (overrun=1).
- No combinational path from rd to uart_rd. The path from uart_valid to uart_rd is combinational.
- Storage: 2**AW x DW register array (LUT/FF); no block RAM dependency.

Test Plan:
- Single byte: reset, then uart_valid=1, uart_data=8'h41 for one cycle -> uart_rd=1 that cycle; next cycle valid=1, data=8'h41, level=1. Pulse rd -> valid=0, level=0.
- Ordering and wrap: push 8'h00..8'h0F (16 bytes, AW=4), pop all, then push 8'h10..8'h17 and pop -> read order exactly 00..17, level returns to 0, no overrun.
- Full/discard: push 17 bytes 8'hA0..8'hB0 with no rd -> uart_rd pulses 17 times, level=16, overrun=1, and pops return A0..AF (B0 lost). clr_overrun -> overrun=0.
- Simultaneous at boundaries:
  - Full with uart_valid and rd in the same cycle -> level stays 16, overrun stays 0, new byte is last out.
  - Empty with both -> byte stored, valid=1 next cycle.
- Set/clear race and empty read: discard in the same cycle as clr_overrun -> overrun=1. rd while empty -> level stays 0, pointers unchanged (next pushed byte is read first).
- Reset mid-stream: 5 bytes queued, overrun=1, assert reset for 1 cycle while uart_valid=1 -> valid=0, level=0, overrun=0, uart_rd=0 during reset; the held byte is accepted the cycle after reset and read back correctly.
